mem_parity_xcvr: RTL and testbench
==================================

// Module: mem_parity_xcvr
// PURPOSE
//  Parametrised data/parity transceiver between the CPU local bus (LBD) and memory data bus (DD).
//  Write path: generates one parity bit per byte lane onto DD.
//  Read path: registers DD, checks parity per lane, and holds sticky error state for the CPU.
//  Error state covers per-lane flags, first-error address capture, an overrun flag and an optional error counter.
//  Replaces fixed two-lane transceiver pairs in the MEM/DATA section.
// PARAMETERS
//  LANES      2   number of byte lanes (DD lane i = bits [9i+8:9i], parity at bit 9i+8)
//  ADDR_W     24  width of captured error address
//  ODD_PARITY 1   1: byte+parity has odd count of ones; 0: even
//  CNT_W      8   width of saturating error counter (used only with MEM_PAR_ERRCNT_EN)
// PORTS
//  sysclk       in   1         system clock, all state on rising edge
//  sys_rst      in   1         asynchronous, active-high reset
//  mwrite       in   1         memory write cycle active
//  rd_strobe    in   1         single-cycle pulse: sample dd_in for read check
//  addr_in      in   ADDR_W    address of current memory cycle
//  par_dis      in   1         1: suppress parity checking (data still registered)
//  clr_err      in   1         single-cycle pulse: clear sticky error state
//  lbd_in       in   LANES*8   CPU write data
//  lbd_out      out  LANES*8   registered read data
//  lbd_oe       out  1         drive lbd_out onto local bus
//  dd_in        in   LANES*9   memory read data + parity
//  dd_out       out  LANES*9   memory write data + generated parity
//  dd_oe        out  1         drive dd_out onto memory bus
//  rd_valid     out  1         one-cycle pulse: lbd_out updated
//  lerr         out  1         one-cycle pulse with rd_valid when any lane failed
//  err_lane     out  LANES     sticky per-lane parity error flags
//  perr_sticky  out  1         OR of err_lane (drives parity LED)
//  err_overrun  out  1         error detected while previous error uncleared
//  err_addr     out  ADDR_W    addr_in of first uncleared error
//  err_cnt      out  CNT_W     saturating count of failing reads
// BEHAVIOUR
//  Reset: all registered outputs 0 (lbd_out, lbd_oe, rd_valid, lerr, err_lane, perr_sticky, err_overrun, err_addr, err_cnt).
//  Reset: state returns to OK.
//  Write path (combinational): dd_oe = mwrite; dd_out lane i = {par(lbd_in byte i), byte i}.
//  Parity function: par = ODD_PARITY ? ~^byte : ^byte.
//  Read path, 1-cycle latency: rd_strobe & ~mwrite at edge N -> edge N+1 gives lbd_out = data bits of dd_in, rd_valid=1, lbd_oe=1.
//  lbd_oe stays 1 until the first cycle mwrite=1, then 0.
//  Collision: rd_strobe while mwrite=1 is ignored (no rd_valid, no check).
//  Lane i fails when ^dd_in lane != ODD_PARITY and par_dis=0.
//  Failing read: lerr=1 together with rd_valid; err_lane |= failing mask.
//  Error FSM, state type err_st_t:
//   OK    + failing read -> ERR; err_addr <= addr_in.
//   ERR   + failing read -> OVR; err_overrun=1; err_addr holds.
//   OVR   + failing read -> OVR; err_addr holds.
//   any   + clr_err -> OK; err_lane, err_overrun, err_addr, err_cnt cleared.
//  clr_err together with a failing read: the clear applies first, then the new error is captured.
//  Result of that case: state ERR, err_lane = new mask only, err_addr = new addr, err_cnt = 1.
//  perr_sticky = |err_lane (registered alongside it).
//  Reset mid-operation aborts a pending read; no rd_valid follows the reset.
// CONFIGURATION
//  MEM_PAR_ERRCNT_EN defined: err_cnt increments by 1 per failing read (not per lane).
//   Saturates at 2^CNT_W-1; cleared by clr_err.
//  MEM_PAR_ERRCNT_EN undefined: counter not built; err_cnt tied to 0.
// STRUCTURE
//  Package mem_par_pkg: err_st_t {OK, ERR, OVR}; constants LANE_DW=8 and LANE_PW=9.
//  Sub-module mem_parity_lane: one byte lane, comprising:
//   write parity generator;
//   read data register;
//   per-lane fail output.
//  Top level instantiates LANES copies and holds the FSM, address capture and counter.
// TESTING  (LANES=2, ODD_PARITY=1, MEM_PAR_ERRCNT_EN defined)
//  Write: mwrite=1, lbd_in=16'h0100 -> dd_oe=1, dd_out=18'h00300.
//  Clean read: rd_strobe, dd_in=18'h00300, addr=24'h001234 -> next cycle rd_valid=1, lbd_out=16'h0100, lerr=0, err_lane=0.
//  Bad lane0: dd_in=18'h00200, addr=24'h00ABCD -> lerr=1, err_lane=2'b01, perr_sticky=1, err_addr=24'h00ABCD, err_cnt=1.
//  Second bad read (lane1, dd_in=18'h00100) before clear -> err_overrun=1, err_lane=2'b11, err_addr unchanged, err_cnt=2.
//  clr_err coincident with bad read at addr 24'h000042 -> err_lane=new mask, err_overrun=0, err_addr=24'h000042, err_cnt=1.
//  par_dis=1 with dd_in=18'h00200 -> no lerr, no flag change; rd_strobe while mwrite=1 -> no rd_valid; sys_rst in OVR -> all outputs 0.

Source files
------------

// File: rtl/mem_par_pkg.sv
// Shared types and lane geometry for the memory data/parity transceiver.
package mem_par_pkg;

    localparam int unsigned LANE_DW = 8;
    localparam int unsigned LANE_PW = 9;

    typedef enum logic [1:0] {
        OK  = 2'd0,
        ERR = 2'd1,
        OVR = 2'd2
    } err_st_t;

    // Parity bit that makes byte+parity odd (odd=1) or even (odd=0).
    function automatic logic gen_par(input logic [LANE_DW-1:0] b, input logic odd);
        return odd ? ~^b : ^b;
    endfunction

endpackage

// File: rtl/mem_parity_lane.sv
// One byte lane: write parity generator, read data register, read parity fail flag.
module mem_parity_lane
    import mem_par_pkg::*;
#(
    parameter bit ODD_PARITY = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               par_dis,
    input  logic [LANE_DW-1:0] wr_byte,
    input  logic [LANE_PW-1:0] rd_lane,
    output logic [LANE_PW-1:0] wr_lane_c,
    output logic [LANE_DW-1:0] rd_byte,
    output logic               fail_c
);

    logic [LANE_DW-1:0] rd_byte_q, rd_byte_d;

    assign wr_lane_c = {gen_par(wr_byte, ODD_PARITY), wr_byte};
    assign fail_c    = rd_en & ~par_dis & ((^rd_lane) != ODD_PARITY);
    assign rd_byte   = rd_byte_q;

    always_comb begin
        rd_byte_d = rd_byte_q;
        if (rd_en) begin
            rd_byte_d = rd_lane[LANE_DW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_byte_q <= '0;
        end else begin
            rd_byte_q <= rd_byte_d;
        end
    end

endmodule

// File: rtl/mem_parity_xcvr.sv
// CPU/memory data transceiver with per-lane parity and sticky error capture.
// Define MEM_PAR_ERRCNT_EN to build the saturating failing-read counter.
module mem_parity_xcvr
    import mem_par_pkg::*;
#(
    parameter int unsigned LANES      = 2,
    parameter int unsigned ADDR_W     = 24,
    parameter bit          ODD_PARITY = 1'b1,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                     sysclk,
    input  logic                     sys_rst,
    input  logic                     mwrite,
    input  logic                     rd_strobe,
    input  logic [ADDR_W-1:0]        addr_in,
    input  logic                     par_dis,
    input  logic                     clr_err,
    input  logic [LANES*LANE_DW-1:0] lbd_in,
    output logic [LANES*LANE_DW-1:0] lbd_out,
    output logic                     lbd_oe,
    input  logic [LANES*LANE_PW-1:0] dd_in,
    output logic [LANES*LANE_PW-1:0] dd_out,
    output logic                     dd_oe,
    output logic                     rd_valid,
    output logic                     lerr,
    output logic [LANES-1:0]         err_lane,
    output logic                     perr_sticky,
    output logic                     err_overrun,
    output logic [ADDR_W-1:0]        err_addr,
    output logic [CNT_W-1:0]         err_cnt
);

    logic             rd_en_c;
    logic [LANES-1:0] fail_mask_c;
    logic             any_fail_c;

    err_st_t           state_q, state_d, st_base;
    logic              rd_valid_q, rd_valid_d;
    logic              lerr_q, lerr_d;
    logic              lbd_oe_q, lbd_oe_d;
    logic [LANES-1:0]  err_lane_q, err_lane_d;
    logic              perr_q, perr_d;
    logic              err_overrun_q, err_overrun_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    assign rd_en_c    = rd_strobe & ~mwrite;
    assign any_fail_c = |fail_mask_c;
    assign dd_oe      = mwrite;

    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        mem_parity_lane #(
            .ODD_PARITY (ODD_PARITY)
        ) u_lane (
            .clk       (sysclk),
            .rst       (sys_rst),
            .rd_en     (rd_en_c),
            .par_dis   (par_dis),
            .wr_byte   (lbd_in[i*LANE_DW +: LANE_DW]),
            .rd_lane   (dd_in[i*LANE_PW +: LANE_PW]),
            .wr_lane_c (dd_out[i*LANE_PW +: LANE_PW]),
            .rd_byte   (lbd_out[i*LANE_DW +: LANE_DW]),
            .fail_c    (fail_mask_c[i])
        );
    end

    // A coincident clear is applied to the held state before a new error is captured.
    always_comb begin
        st_base       = clr_err ? OK : state_q;
        state_d       = st_base;
        err_lane_d    = (clr_err ? '0 : err_lane_q) | fail_mask_c;
        perr_d        = |err_lane_d;
        err_overrun_d = clr_err ? 1'b0 : err_overrun_q;
        err_addr_d    = clr_err ? '0 : err_addr_q;
        rd_valid_d    = rd_en_c;
        lerr_d        = any_fail_c;
        lbd_oe_d      = lbd_oe_q;
        if (mwrite) begin
            lbd_oe_d = 1'b0;
        end else if (rd_en_c) begin
            lbd_oe_d = 1'b1;
        end
        if (any_fail_c) begin
            case (st_base)
                OK: begin
                    state_d    = ERR;
                    err_addr_d = addr_in;
                end
                ERR, OVR: begin
                    state_d       = OVR;
                    err_overrun_d = 1'b1;
                end
                default: state_d = OK;
            endcase
        end
    end

    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= OK;
            rd_valid_q    <= 1'b0;
            lerr_q        <= 1'b0;
            lbd_oe_q      <= 1'b0;
            err_lane_q    <= '0;
            perr_q        <= 1'b0;
            err_overrun_q <= 1'b0;
            err_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            rd_valid_q    <= rd_valid_d;
            lerr_q        <= lerr_d;
            lbd_oe_q      <= lbd_oe_d;
            err_lane_q    <= err_lane_d;
            perr_q        <= perr_d;
            err_overrun_q <= err_overrun_d;
            err_addr_q    <= err_addr_d;
        end
    end

    assign rd_valid    = rd_valid_q;
    assign lerr        = lerr_q;
    assign lbd_oe      = lbd_oe_q;
    assign err_lane    = err_lane_q;
    assign perr_sticky = perr_q;
    assign err_overrun = err_overrun_q;
    assign err_addr    = err_addr_q;

`ifdef MEM_PAR_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Counts failing reads, not failing lanes; sticks at all-ones.
    always_comb begin
        err_cnt_d = clr_err ? '0 : err_cnt_q;
        if (any_fail_c && (err_cnt_d != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_parity_xcvr.sv
// Directed scoreboard bench for mem_parity_xcvr (LANES=2, odd parity).
module tb_mem_parity_xcvr;

    logic        sysclk = 1'b0;
    logic        sys_rst;
    logic        mwrite, rd_strobe, par_dis, clr_err;
    logic [23:0] addr_in;
    logic [15:0] lbd_in, lbd_out;
    logic [17:0] dd_in, dd_out;
    logic        lbd_oe, dd_oe, rd_valid, lerr, perr_sticky, err_overrun;
    logic [1:0]  err_lane;
    logic [23:0] err_addr;
    logic [7:0]  err_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        v;
        logic [15:0] lbd;
        logic        oe;
        logic        lerr;
        logic [1:0]  lane;
        logic        ovr;
        logic [23:0] addr;
        logic [7:0]  cnt;
    } exp_t;

    exp_t sb[$];

    always #5 sysclk = ~sysclk;

    mem_parity_xcvr dut (
        .sysclk      (sysclk),
        .sys_rst     (sys_rst),
        .mwrite      (mwrite),
        .rd_strobe   (rd_strobe),
        .addr_in     (addr_in),
        .par_dis     (par_dis),
        .clr_err     (clr_err),
        .lbd_in      (lbd_in),
        .lbd_out     (lbd_out),
        .lbd_oe      (lbd_oe),
        .dd_in       (dd_in),
        .dd_out      (dd_out),
        .dd_oe       (dd_oe),
        .rd_valid    (rd_valid),
        .lerr        (lerr),
        .err_lane    (err_lane),
        .perr_sticky (perr_sticky),
        .err_overrun (err_overrun),
        .err_addr    (err_addr),
        .err_cnt     (err_cnt)
    );

    // Expected counter value after n failing reads since the last clear.
    function automatic logic [7:0] ec(input int n);
`ifdef MEM_PAR_ERRCNT_EN
        return (n > 255) ? 8'd255 : 8'(n);
`else
        return 8'(n & 0);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic v, input logic [15:0] lbd, input logic oe, input logic le,
                        input logic [1:0] lane, input logic ovr, input logic [23:0] a, input logic [7:0] c);
        exp_t e;
        e.v = v; e.lbd = lbd; e.oe = oe; e.lerr = le;
        e.lane = lane; e.ovr = ovr; e.addr = a; e.cnt = c;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, ".rd_valid"},    32'(rd_valid),    32'(e.v));
            chk({tag, ".lbd_out"},     32'(lbd_out),     32'(e.lbd));
            chk({tag, ".lbd_oe"},      32'(lbd_oe),      32'(e.oe));
            chk({tag, ".lerr"},        32'(lerr),        32'(e.lerr));
            chk({tag, ".err_lane"},    32'(err_lane),    32'(e.lane));
            chk({tag, ".perr_sticky"}, 32'(perr_sticky), 32'(|e.lane));
            chk({tag, ".err_overrun"}, 32'(err_overrun), 32'(e.ovr));
            chk({tag, ".err_addr"},    32'(err_addr),    32'(e.addr));
            chk({tag, ".err_cnt"},     32'(err_cnt),     32'(e.cnt));
        end
    endtask

    // Drive one cycle of inputs, then compare registered outputs after the edge.
    task automatic cyc(input string tag, input logic mw, input logic rs, input logic clr,
                       input logic pd, input logic [23:0] a, input logic [17:0] d, input logic [15:0] lb);
        @(negedge sysclk);
        mwrite = mw; rd_strobe = rs; clr_err = clr; par_dis = pd;
        addr_in = a; dd_in = d; lbd_in = lb;
        @(posedge sysclk);
        #1;
        pop_chk(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sys_rst = 1'b1; mwrite = 1'b0; rd_strobe = 1'b0; par_dis = 1'b0; clr_err = 1'b0;
        addr_in = '0; dd_in = '0; lbd_in = '0;
        repeat (2) @(posedge sysclk);
        #1;
        push(0, 16'h0000, 0, 0, 2'b00, 0, 24'h0, 8'h0);
        pop_chk("reset");
        chk("reset.dd_oe", 32'(dd_oe), 32'h0);
        chk("reset.dd_out", 32'(dd_out), 32'h20100);
        @(negedge sysclk);
        sys_rst = 1'b0;

        // Write path
        push(0, 16'h0000, 0, 0, 2'b00, 0, 24'h0, 8'h0);
        cyc("write0", 1, 0, 0, 0, 24'h0, 18'h0, 16'h0100);
        chk("write0.dd_oe", 32'(dd_oe), 32'h1);
        chk("write0.dd_out", 32'(dd_out), 32'h00300);
        push(0, 16'h0000, 0, 0, 2'b00, 0, 24'h0, 8'h0);
        cyc("write1", 1, 0, 0, 0, 24'h0, 18'h0, 16'hFF03);
        chk("write1.dd_out", 32'(dd_out), 32'h3FF03);
        push(0, 16'h0000, 0, 0, 2'b00, 0, 24'h0, 8'h0);
        cyc("write2", 1, 0, 0, 0, 24'h0, 18'h0, 16'h8001);
        chk("write2.dd_out", 32'(dd_out), 32'h10001);

        // Read path and error FSM
        push(1, 16'h0100, 1, 0, 2'b00, 0, 24'h0, ec(0));
        cyc("clean_rd", 0, 1, 0, 0, 24'h001234, 18'h00300, 16'h0);
        chk("clean_rd.dd_oe", 32'(dd_oe), 32'h0);
        push(0, 16'h0100, 1, 0, 2'b00, 0, 24'h0, ec(0));
        cyc("idle0", 0, 0, 0, 0, 24'h0, 18'h00300, 16'h0);
        push(1, 16'h0100, 1, 1, 2'b01, 0, 24'h00ABCD, ec(1));
        cyc("bad_l0", 0, 1, 0, 0, 24'h00ABCD, 18'h00200, 16'h0);
        push(1, 16'h0000, 1, 1, 2'b11, 1, 24'h00ABCD, ec(2));
        cyc("bad_l1_ovr", 0, 1, 0, 0, 24'h001111, 18'h00100, 16'h0);
        push(1, 16'h0100, 1, 1, 2'b11, 1, 24'h00ABCD, ec(3));
        cyc("bad_in_ovr", 0, 1, 0, 0, 24'h000777, 18'h00200, 16'h0);
        push(1, 16'h0100, 1, 1, 2'b01, 0, 24'h000042, ec(1));
        cyc("clr_and_bad", 0, 1, 1, 0, 24'h000042, 18'h00200, 16'h0);
        push(1, 16'h0100, 1, 0, 2'b01, 0, 24'h000042, ec(1));
        cyc("par_dis", 0, 1, 0, 1, 24'h000999, 18'h00200, 16'h0);
        push(0, 16'h0100, 1, 0, 2'b00, 0, 24'h0, ec(0));
        cyc("clr_only", 0, 0, 1, 0, 24'h0, 18'h0, 16'h0);
        push(1, 16'h0000, 1, 1, 2'b10, 0, 24'h000055, ec(1));
        cyc("bad_after_clr", 0, 1, 0, 0, 24'h000055, 18'h00100, 16'h0);
        push(0, 16'h0000, 0, 0, 2'b10, 0, 24'h000055, ec(1));
        cyc("collision", 1, 1, 0, 0, 24'h000066, 18'h00200, 16'h0);
        push(1, 16'hFF03, 1, 0, 2'b10, 0, 24'h000055, ec(1));
        cyc("clean_ff03", 0, 1, 0, 0, 24'h000077, 18'h3FF03, 16'h0);
        push(1, 16'h0000, 1, 1, 2'b11, 1, 24'h000055, ec(2));
        cyc("bad_both", 0, 1, 0, 0, 24'h000088, 18'h00000, 16'h0);
        push(0, 16'h0000, 1, 0, 2'b00, 0, 24'h0, ec(0));
        cyc("clr_pre_sat", 0, 0, 1, 0, 24'h0, 18'h0, 16'h0);

        // Counter saturation: one failing read per cycle
        for (int k = 1; k <= 260; k++) begin
            push(1, 16'h0000, 1, 1, 2'b11, (k >= 2), 24'h000001, ec(k));
            cyc("sat", 0, 1, 0, 0, 24'(k), 18'h00000, 16'h0);
        end

        // Reset while a read is pending in OVR
        @(negedge sysclk);
        rd_strobe = 1'b1; dd_in = 18'h00200; addr_in = 24'h000123;
        #2 sys_rst = 1'b1;
        @(posedge sysclk);
        #1;
        push(0, 16'h0000, 0, 0, 2'b00, 0, 24'h0, 8'h0);
        pop_chk("rst_mid");
        @(negedge sysclk);
        sys_rst = 1'b0; rd_strobe = 1'b0;
        @(posedge sysclk);
        #1;
        push(0, 16'h0000, 0, 0, 2'b00, 0, 24'h0, 8'h0);
        pop_chk("post_rst");

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
